code_counter: RTL

Synthesisable, parametrised successor of the simulation stimulus generators for binary, BCD, Gray, Aiken and Stibitz codes. Multi-digit up/down counter whose digits are emitted in a selectable 4-bit code, with wrap or saturate at the range ends, parallel load and an overflow pulse. Drives 7-seg decoders, LED banks and test benches from real clocked logic instead of `#2` delays.

---
 rtl/code_pkg.sv | 28 ++
 rtl/code_digit.sv | 46 ++++
 rtl/code_counter.sv | 56 +++++
 3 files changed

// File: rtl/code_pkg.sv
// Shared code definitions: radix and 4-bit encoding of a digit index for each
// supported code.
package code_pkg;

  localparam int unsigned CODE_BIN     = 0;
  localparam int unsigned CODE_BCD     = 1;
  localparam int unsigned CODE_GRAY    = 2;
  localparam int unsigned CODE_AIKEN   = 3;
  localparam int unsigned CODE_STIBITZ = 4;

  function automatic logic [4:0] code_radix(input int unsigned mode);
    case (mode)
      CODE_BCD, CODE_AIKEN, CODE_STIBITZ: return 5'd10;
      default:                            return 5'd16;
    endcase
  endfunction

  function automatic logic [3:0] code_encode(input int unsigned mode, input logic [3:0] idx);
    case (mode)
      CODE_GRAY:    return idx ^ (idx >> 1);
      // Aiken 2421 skips the six codes 0101..1010
      CODE_AIKEN:   return (idx < 4'd5) ? idx : idx + 4'd6;
      CODE_STIBITZ: return idx + 4'd3;
      default:      return idx;
    endcase
  endfunction

endpackage

// File: rtl/code_digit.sv
// One counter digit: index register with clamped load, up/down step on
// carry_in, and encoded output.
module code_digit
  import code_pkg::*;
#(
  parameter int unsigned MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carry_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_idx,
  output logic [3:0] code,
  output logic       at_lim,
  output logic       carry_out
);

  localparam logic [4:0] Radix  = code_radix(MODE);
  localparam logic [3:0] MaxIdx = 4'(Radix - 5'd1);

  logic [3:0] idx_q, idx_d;
  logic [3:0] load_clamped;

  always_comb begin
    load_clamped = ({1'b0, load_idx} >= Radix) ? MaxIdx : load_idx;
    at_lim       = up ? (idx_q == MaxIdx) : (idx_q == 4'd0);
    carry_out    = carry_in & at_lim;

    idx_d = idx_q;
    if (load) begin
      idx_d = load_clamped;
    end else if (carry_in) begin
      if (up) idx_d = at_lim ? 4'd0 : idx_q + 4'd1;
      else    idx_d = at_lim ? MaxIdx : idx_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= 4'd0;
    else     idx_q <= idx_d;
  end

  assign code = code_encode(MODE, idx_q);

endmodule

// File: rtl/code_counter.sv
// Multi-digit up/down counter emitting each digit in a selectable 4-bit code,
// with wrap or saturate at the range ends, parallel load and overflow pulse.
module code_counter
  import code_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned MODE   = 0,
  parameter int unsigned WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_idx,
  output logic [4*DIGITS-1:0]   q,
  output logic                  ovf,
  output logic                  at_lim
);

  localparam bit Saturate = (WRAP == 0);

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] dig_lim;
  logic              ovf_d;

  assign at_lim = &dig_lim;

  // Saturation blocks the step at digit 0, so no digit ever moves at the limit.
  assign carry[0] = en & ~(Saturate & at_lim);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    code_digit #(
      .MODE(MODE)
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .carry_in (carry[g]),
      .up       (up),
      .load     (load),
      .load_idx (load_idx[4*g +: 4]),
      .code     (q[4*g +: 4]),
      .at_lim   (dig_lim[g]),
      .carry_out(carry[g+1])
    );
  end

  // Ripple out of the top digit is a wrap; a blocked step is a saturation hit.
  assign ovf_d = ~load & (carry[DIGITS] | (Saturate & en & at_lim));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= ovf_d;
  end

endmodule
